// File: rtl/branch_predict_controller_if.sv
// rtl/branch_predict_controller_if.sv - pipeline-side bundle for the branch predictor
//
// Purpose: groups the fetch/decode/execute signals exchanged between the core
// pipeline and branch_predict_controller.
// Ports (signals):
//   PCF         Fetch PC                            (pipeline -> predictor)
//   StallD      hold F->D prediction register       (pipeline -> predictor)
//   FlushD      clear F->D prediction register      (pipeline -> predictor)
//   FlushE      clear D->E prediction register      (pipeline -> predictor)
//   PCE         Execute-stage PC                    (pipeline -> predictor)
//   BranchOpE   00 none, 01 jump, 10 cond, 11 none  (pipeline -> predictor)
//   PCSrcE      actual taken                        (pipeline -> predictor)
//   PCTargetE   computed target in E                (pipeline -> predictor)
//   PredTakenF  predict taken at Fetch              (predictor -> pipeline)
//   PredTargetF predicted target at Fetch           (predictor -> pipeline)
//   MispredictE prediction in E was wrong           (predictor -> pipeline)
//   RedirectSrcE 1 = fetch PCTargetE, 0 = PCE+4     (predictor -> pipeline)
// Modports: master = pipeline side, slave = predictor.
interface branch_predict_controller_if;
  logic [31:0] PCF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic [31:0] PCE;
  logic [1:0]  BranchOpE;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        MispredictE;
  logic        RedirectSrcE;

  modport master (
    output PCF, StallD, FlushD, FlushE, PCE, BranchOpE, PCSrcE, PCTargetE,
    input  PredTakenF, PredTargetF, MispredictE, RedirectSrcE
  );

  modport slave (
    input  PCF, StallD, FlushD, FlushE, PCE, BranchOpE, PCSrcE, PCTargetE,
    output PredTakenF, PredTargetF, MispredictE, RedirectSrcE
  );
endinterface

// File: rtl/branch_predict_controller.sv
// rtl/branch_predict_controller.sv - fetch branch predictor and execute mispredict controller
//
// Purpose: direct-mapped table of 2-bit saturating counters plus targets,
// looked up combinationally at Fetch; the prediction rides the F->D and D->E
// registers and is checked against the resolved outcome in Execute, which
// also trains the table.
// Ports:
//   clk    core clock, rising edge
//   reset  synchronous, active-high; clears table and pipeline registers
//   bp     branch_predict_controller_if.slave (see interface header)
module branch_predict_controller #(
  parameter int INDEX_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  branch_predict_controller_if.slave    bp
);
  localparam int DEPTH = 1 << INDEX_WIDTH;

  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_COND = 2'b10;

  logic              valid_q  [DEPTH];
  logic              valid_d  [DEPTH];
  logic [1:0]        ctr_q    [DEPTH];
  logic [1:0]        ctr_d    [DEPTH];
  logic [31:0]       target_q [DEPTH];
  logic [31:0]       target_d [DEPTH];

  logic              pred_taken_dstg_q, pred_taken_dstg_d;
  logic [31:0]       pred_target_dstg_q, pred_target_dstg_d;
  logic              pred_taken_estg_q, pred_taken_estg_d;
  logic [31:0]       pred_target_estg_q, pred_target_estg_d;

  logic [INDEX_WIDTH-1:0] f_idx;
  logic [INDEX_WIDTH-1:0] e_idx;
  logic                   is_branch_e;

  // Only the index bits of the PCs select an entry; the rest are ignored
  // on purpose (no tags, aliasing is repaired by the mispredict path).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.PCF[31:INDEX_WIDTH+2], bp.PCF[1:0],
                            bp.PCE[31:INDEX_WIDTH+2], bp.PCE[1:0]};

  assign f_idx       = bp.PCF[INDEX_WIDTH+1:2];
  assign e_idx       = bp.PCE[INDEX_WIDTH+1:2];
  assign is_branch_e = (bp.BranchOpE == OP_JUMP) || (bp.BranchOpE == OP_COND);

  // Fetch lookup reads the registered table, so a same-cycle update is not
  // bypassed and only becomes visible after the edge.
  assign bp.PredTakenF  = valid_q[f_idx] & ctr_q[f_idx][1];
  assign bp.PredTargetF = target_q[f_idx];

  always_comb begin
    pred_taken_dstg_d  = pred_taken_dstg_q;
    pred_target_dstg_d = pred_target_dstg_q;
    if (!bp.StallD) begin
      if (bp.FlushD) begin
        pred_taken_dstg_d  = 1'b0;
        pred_target_dstg_d = 32'h0;
      end else begin
        pred_taken_dstg_d  = bp.PredTakenF;
        pred_target_dstg_d = bp.PredTargetF;
      end
    end

    pred_taken_estg_d  = pred_taken_dstg_q;
    pred_target_estg_d = pred_target_dstg_q;
    if (bp.FlushE) begin
      pred_taken_estg_d  = 1'b0;
      pred_target_estg_d = 32'h0;
    end
  end

  always_comb begin
    bp.MispredictE  = 1'b0;
    bp.RedirectSrcE = 1'b0;
    if (is_branch_e) begin
      if (pred_taken_estg_q != bp.PCSrcE) begin
        bp.MispredictE = 1'b1;
      end else if (pred_taken_estg_q && bp.PCSrcE &&
                   (pred_target_estg_q != bp.PCTargetE)) begin
        bp.MispredictE = 1'b1;
      end
      bp.RedirectSrcE = bp.MispredictE & bp.PCSrcE;
    end else if (pred_taken_estg_q) begin
      // A non-branch predicted taken is an alias hit: resume at PCE+4.
      bp.MispredictE = 1'b1;
    end
  end

  // Training depends only on the E-stage inputs, not on MispredictE.
  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    target_d = target_q;
    if (bp.BranchOpE == OP_COND) begin
      if (!valid_q[e_idx]) begin
        valid_d[e_idx]  = 1'b1;
        ctr_d[e_idx]    = bp.PCSrcE ? 2'b10 : 2'b01;
        target_d[e_idx] = bp.PCTargetE;
      end else if (bp.PCSrcE) begin
        if (ctr_q[e_idx] != 2'b11) begin
          ctr_d[e_idx] = ctr_q[e_idx] + 2'b01;
        end
        target_d[e_idx] = bp.PCTargetE;
      end else if (ctr_q[e_idx] != 2'b00) begin
        ctr_d[e_idx] = ctr_q[e_idx] - 2'b01;
      end
    end else if (bp.BranchOpE == OP_JUMP) begin
      valid_d[e_idx]  = 1'b1;
      ctr_d[e_idx]    = 2'b11;
      target_d[e_idx] = bp.PCTargetE;
    end else if (pred_taken_estg_q) begin
      valid_d[e_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q            <= '{default: 1'b0};
      ctr_q              <= '{default: 2'b01};
      target_q           <= '{default: 32'h0};
      pred_taken_dstg_q  <= 1'b0;
      pred_target_dstg_q <= 32'h0;
      pred_taken_estg_q  <= 1'b0;
      pred_target_estg_q <= 32'h0;
    end else begin
      valid_q            <= valid_d;
      ctr_q              <= ctr_d;
      target_q           <= target_d;
      pred_taken_dstg_q  <= pred_taken_dstg_d;
      pred_target_dstg_q <= pred_target_dstg_d;
      pred_taken_estg_q  <= pred_taken_estg_d;
      pred_target_estg_q <= pred_target_estg_d;
    end
  end
endmodule

// File: tb/tb_branch_predict_controller.sv
// tb/tb_branch_predict_controller.sv - directed self-checking bench for branch_predict_controller
module tb_branch_predict_controller;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  branch_predict_controller_if bp_if ();

  branch_predict_controller #(.INDEX_WIDTH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_e(input logic [31:0] pce, input logic [1:0] op,
                       input logic src, input logic [31:0] tgt);
    bp_if.PCE       = pce;
    bp_if.BranchOpE = op;
    bp_if.PCSrcE    = src;
    bp_if.PCTargetE = tgt;
  endtask

  initial begin
    reset        = 1'b1;
    bp_if.PCF    = 32'h0;
    bp_if.StallD = 1'b0;
    bp_if.FlushD = 1'b0;
    bp_if.FlushE = 1'b0;
    set_e(32'h0, 2'b00, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    bp_if.PCF = 32'h100;
    set_e(32'h100, 2'b00, 1'b0, 32'h0);
    #1;
    chk("rst_pred_taken", 32'(bp_if.PredTakenF), 32'd0);
    chk("rst_pred_target", bp_if.PredTargetF, 32'h0);
    chk("rst_mispredict", 32'(bp_if.MispredictE), 32'd0);
    chk("rst_redirect", 32'(bp_if.RedirectSrcE), 32'd0);

    // Cold conditional taken at 0x40 -> 0x80; same-cycle read sees old entry
    bp_if.PCF = 32'h40;
    set_e(32'h40, 2'b10, 1'b1, 32'h80);
    #1;
    chk("cold_cond_mispredict", 32'(bp_if.MispredictE), 32'd1);
    chk("cold_cond_redirect", 32'(bp_if.RedirectSrcE), 32'd1);
    chk("no_bypass_pred_taken", 32'(bp_if.PredTakenF), 32'd0);
    tick();
    set_e(32'h40, 2'b00, 1'b0, 32'h0);
    #1;
    chk("trained_pred_taken", 32'(bp_if.PredTakenF), 32'd1);
    chk("trained_pred_target", bp_if.PredTargetF, 32'h80);
    tick();
    tick();

    // Prediction now in E: three more taken resolutions, correctly predicted
    set_e(32'h40, 2'b10, 1'b1, 32'h80);
    #1;
    chk("taken2_mispredict", 32'(bp_if.MispredictE), 32'd0);
    tick();
    chk("taken3_mispredict", 32'(bp_if.MispredictE), 32'd0);
    tick();
    tick();

    // Two not-taken: ctr 11 -> 10 -> 01
    set_e(32'h40, 2'b10, 1'b0, 32'h80);
    #1;
    chk("nt1_mispredict", 32'(bp_if.MispredictE), 32'd1);
    chk("nt1_redirect", 32'(bp_if.RedirectSrcE), 32'd0);
    tick();
    chk("nt1_pred_taken", 32'(bp_if.PredTakenF), 32'd1);
    chk("nt1_pred_target", bp_if.PredTargetF, 32'h80);
    chk("nt2_mispredict", 32'(bp_if.MispredictE), 32'd1);
    chk("nt2_redirect", 32'(bp_if.RedirectSrcE), 32'd0);
    bp_if.FlushD = 1'b1;
    bp_if.FlushE = 1'b1;
    tick();
    bp_if.FlushD = 1'b0;
    bp_if.FlushE = 1'b0;
    chk("nt2_pred_taken", 32'(bp_if.PredTakenF), 32'd0);

    // Cold jump 0x200 -> 0x300
    bp_if.PCF = 32'h100;
    set_e(32'h200, 2'b01, 1'b1, 32'h300);
    #1;
    chk("cold_jump_mispredict", 32'(bp_if.MispredictE), 32'd1);
    chk("cold_jump_redirect", 32'(bp_if.RedirectSrcE), 32'd1);
    tick();
    set_e(32'h200, 2'b00, 1'b0, 32'h0);
    bp_if.PCF = 32'h200;
    #1;
    chk("jump_pred_taken", 32'(bp_if.PredTakenF), 32'd1);
    chk("jump_pred_target", bp_if.PredTargetF, 32'h300);
    tick();
    tick();

    // Jump prediction in E: matching target, then retarget to 0x340
    set_e(32'h200, 2'b01, 1'b1, 32'h300);
    #1;
    chk("jump_match_mispredict", 32'(bp_if.MispredictE), 32'd0);
    set_e(32'h200, 2'b01, 1'b1, 32'h340);
    #1;
    chk("jump_retarget_mispredict", 32'(bp_if.MispredictE), 32'd1);
    chk("jump_retarget_redirect", 32'(bp_if.RedirectSrcE), 32'd1);
    tick();
    chk("retarget_pred_target", bp_if.PredTargetF, 32'h340);
    chk("retarget_pred_taken", 32'(bp_if.PredTakenF), 32'd1);

    // Retrain entry 16 (ctr 01 -> 10 -> 11), fetching the alias 0x140
    bp_if.PCF = 32'h140;
    set_e(32'h40, 2'b10, 1'b1, 32'h80);
    tick();
    tick();
    set_e(32'h40, 2'b00, 1'b0, 32'h0);
    tick();

    // Alias: non-branch at 0x140 carried a taken prediction
    set_e(32'h140, 2'b00, 1'b1, 32'h999);
    #1;
    chk("alias_mispredict", 32'(bp_if.MispredictE), 32'd1);
    chk("alias_redirect", 32'(bp_if.RedirectSrcE), 32'd0);
    tick();
    bp_if.PCF = 32'h40;
    #1;
    chk("alias_pred_taken", 32'(bp_if.PredTakenF), 32'd0);
    chk("alias_target_kept", bp_if.PredTargetF, 32'h80);

    // StallD holds a taken prediction in D while Fetch moves to a cold PC
    bp_if.PCF = 32'h200;
    set_e(32'h8, 2'b00, 1'b0, 32'h0);
    tick();
    bp_if.StallD = 1'b1;
    bp_if.PCF    = 32'h8;
    tick();
    tick();
    bp_if.StallD = 1'b0;
    set_e(32'h200, 2'b01, 1'b1, 32'h340);
    #1;
    chk("stall_held_mispredict", 32'(bp_if.MispredictE), 32'd0);
    chk("stall_held_redirect", 32'(bp_if.RedirectSrcE), 32'd0);

    // FlushE clears a taken prediction on its way into E
    bp_if.PCF = 32'h200;
    tick();
    bp_if.FlushE = 1'b1;
    tick();
    bp_if.FlushE = 1'b0;
    set_e(32'h200, 2'b10, 1'b0, 32'h0);
    #1;
    chk("flushe_mispredict", 32'(bp_if.MispredictE), 32'd0);
    chk("flushe_redirect", 32'(bp_if.RedirectSrcE), 32'd0);

    // Reset with a pending update: update discarded, table cleared
    set_e(32'h40, 2'b10, 1'b1, 32'h80);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bp_if.PCF = 32'h40;
    #1;
    chk("midrst_pred_taken_40", 32'(bp_if.PredTakenF), 32'd0);
    chk("midrst_pred_target_40", bp_if.PredTargetF, 32'h0);
    bp_if.PCF = 32'h200;
    #1;
    chk("midrst_pred_taken_200", 32'(bp_if.PredTakenF), 32'd0);
    chk("midrst_pred_target_200", bp_if.PredTargetF, 32'h0);
    chk("midrst_cond_taken_mispredict", 32'(bp_if.MispredictE), 32'd1);
    set_e(32'h40, 2'b10, 1'b0, 32'h0);
    #1;
    chk("midrst_cond_nt_mispredict", 32'(bp_if.MispredictE), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_predict_controller.md
Name: branch_predict_controller

Overview:
- Fetch-stage branch predictor and Execute-stage mispredict controller for the 5-stage pipelined RV32I core.
- Holds a direct-mapped table of 2-bit saturating counters with target addresses, and supplies a predicted next-PC at Fetch.
- Carries each prediction down to Execute and compares it against the branch resolution unit's PCSrc and the computed target.
- Raises a mispredict/redirect to the hazard unit and PC mux, and updates the table.

Parameters:
- INDEX_WIDTH, 6, table index bits; table depth = 2**INDEX_WIDTH, indexed by PC[INDEX_WIDTH+1:2].

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous, active-high
- PCF  input  32  Fetch PC
- StallD  input  1  hold F->D prediction register
- FlushD  input  1  clear F->D prediction register
- FlushE  input  1  clear D->E prediction register
- PCE  input  32  Execute-stage PC of the instruction in E
- BranchOpE  input  2  00 non-branch, 01 jump, 10 conditional, 11 reserved (treated as 00)
- PCSrcE  input  1  actual taken, from branch resolution unit
- PCTargetE  input  32  computed branch/jump target in E
- PredTakenF  output  1  predict taken at Fetch
- PredTargetF  output  32  predicted target at Fetch
- MispredictE  output  1  prediction in E was wrong; upstream flushes F/D
- RedirectSrcE  output  1  on mispredict: 1 = fetch PCTargetE, 0 = fetch PCE+4

Behaviour:
- Entry contents: valid, ctr[1:0], target[31:0]. There is no tag, so aliasing is permitted and corrected by the mispredict logic.
- Reset, synchronous, takes effect on the first rising edge with reset=1:
  - All entries: valid=0, ctr=01, target=0.
  - Pipeline registers PredTakenD/E=0, PredTargetD/E=0.
  - Reset overrides any concurrent update.
- Fetch lookup is combinational on PCF:
  - PredTakenF = valid & ctr[1].
  - PredTargetF = entry target.
- F->D register:
  - StallD=1 holds its value.
  - Otherwise FlushD=1 loads 0.
  - Otherwise it loads {PredTakenF, PredTargetF}.
  - StallD has priority over FlushD.
- D->E register:
  - FlushE=1 loads 0.
  - Otherwise it loads the D values.
  - There is no E stall.
- Mispredict, combinational in E, with taken = PCSrcE:
  - BranchOpE = 01 or 10:
    - Mispredict if PredTakenE != PCSrcE.
    - Also mispredict if PredTakenE=1, PCSrcE=1 and PredTargetE != PCTargetE.
  - BranchOpE = 00 or 11 with PredTakenE=1: mispredict (alias); RedirectSrcE=0.
  - Otherwise MispredictE=0.
  - RedirectSrcE = PCSrcE for branch/jump; 0 for non-branch. It is valid only when MispredictE=1 and is 0 otherwise.
- Table update happens at the rising edge, at index PCE[INDEX_WIDTH+1:2]. It depends only on E-stage inputs, not on MispredictE.
  - Conditional, entry invalid:
    - Set valid=1.
    - Set ctr=10 if taken, else 01.
    - Set target=PCTargetE.
  - Conditional, entry valid:
    - If taken: ctr saturating increment (11 stays 11) and target=PCTargetE.
    - If not taken: saturating decrement (00 stays 00), target unchanged.
  - Jump: valid=1, ctr=11, target=PCTargetE.
  - Non-branch that was predicted taken: valid=0; ctr and target unchanged.
  - Non-branch not predicted taken: no write.
- Same-cycle read and write to the same index: the Fetch read returns the pre-write value (no bypass). The new value is visible the next cycle.
- Reset mid-operation: all state is cleared on that edge, and outputs reflect the reset table the same cycle after the edge.

Test Plan:
- Reset, then PCF=0x100 → PredTakenF=0, PredTargetF=0. Put BranchOpE=00, PCE=0x100 in E → MispredictE=0, RedirectSrcE=0.
- Conditional at PCE=0x40, PCSrcE=1, PCTargetE=0x80, cold entry → MispredictE=1, RedirectSrcE=1. Next cycle PCF=0x40 → PredTakenF=1, PredTargetF=0x80.
- Same branch resolved taken 3 more times (ctr reaches 11), then not-taken twice → ctr 10 then 01. PredTakenF at 0x40 is 1 after the first not-taken and 0 after the second. The predicted-taken/not-taken resolution gives MispredictE=1, RedirectSrcE=0.
- Jump at PCE=0x200 to 0x300, cold → MispredictE=1, RedirectSrcE=1. Re-fetch 0x200 → PredTakenF=1, PredTargetF=0x300. Then the jump retargets to 0x340 with PredTakenE=1 → MispredictE=1 (target mismatch), and the entry target becomes 0x340.
- Alias: PCE=0x40+(4<<INDEX_WIDTH)=0x140 non-branch, with PredTakenE=1 → MispredictE=1, RedirectSrcE=0. Entry valid clears, and PCF=0x40 → PredTakenF=0.
- Pipeline control: with StallD=1 for 2 cycles, PredTakenD holds. FlushE=1 → PredTakenE=0, and a conditional not-taken in E then gives MispredictE=0. Asserting reset with a pending update → table cleared and the update discarded.
